clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider, the parametrised successor to the fixed divide-by-5 divider. It divides `clk_in` by any ratio N in 2..2^DIV_W-1, odd or even, with optional 50 % duty for odd N. The ratio can be changed on the fly without glitches: a new ratio takes effect only at a period boundary. The block sits in the clock-generation area and feeds low-rate peripheral clocks and their period-strobe consumers.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_duty_fix.sv | 23 ++
 rtl/clk_div_prog.sv | 143 ++++++++++++++
 tb/tb_clk_div_prog.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clk_div_state_e;

    localparam int CLK_DIV_MIN = 2;

    // High-phase length H: N/2 for even N, (N+1)/2 for odd N; the extra bit keeps N = max from wrapping.
    function automatic logic [31:0] clk_div_half(input logic [31:0] n);
        logic [32:0] sum;
        sum = {1'b0, n} + {32'd0, n[0]};
        return sum[32:1];
    endfunction

endpackage

// File: rtl/clk_div_duty_fix.sv
// Falling-edge retiming stage that trims odd-ratio high phases to exactly N/2 input periods.
module clk_div_duty_fix (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pos_hi_i,
    input  logic odd_i,
    output logic clk_o
);

    logic neg_hi_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            neg_hi_q <= 1'b0;
        end else begin
            neg_hi_q <= pos_hi_i;
        end
    end

    // AND with the half-cycle-delayed copy: rises half a cycle late, falls on the rising edge.
    assign clk_o = odd_i ? (pos_hi_i & neg_hi_q) : pos_hi_i;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free ratio changes at period boundaries.
// Define CLK_DIV_ODD_DUTY50_EN to get 50 % duty for odd ratios via a falling-edge stage.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] div_cur,
    output logic             cfg_err
);

    clk_div_state_e   state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             pos_hi_q, pos_hi_d;
    logic             cfg_err_q, cfg_err_d;

    logic             load_legal;
    logic             load_bad;
    logic             at_end;
    logic [DIV_W-1:0] count_inc;
    logic [DIV_W-1:0] half_cur;

    assign load_legal = div_load && (div_val >= DIV_W'(CLK_DIV_MIN));
    assign load_bad   = div_load && (div_val <  DIV_W'(CLK_DIV_MIN));
    assign at_end     = (count_q == (div_cur_q - DIV_W'(1)));
    assign count_inc  = count_q + DIV_W'(1);
    assign half_cur   = DIV_W'(clk_div_half(32'(div_cur_q)));

    // State register
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a running period always completes before stopping
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (at_end && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter, phase and ratio bookkeeping
    always_comb begin
        count_d   = count_q;
        pos_hi_d  = pos_hi_q;
        div_cur_d = div_cur_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        cfg_err_d = load_bad;
        case (state_q)
            IDLE: begin
                count_d  = '0;
                pos_hi_d = enable;
                if (load_legal) begin
                    div_cur_d = div_val;
                end
            end
            RUN: begin
                if (at_end) begin
                    // Period boundary: a same-edge load wins over the shadow copy.
                    count_d   = '0;
                    pos_hi_d  = enable;
                    pending_d = 1'b0;
                    if (load_legal) begin
                        div_cur_d = div_val;
                    end else if (pending_q) begin
                        div_cur_d = shadow_q;
                    end
                end else begin
                    count_d  = count_inc;
                    pos_hi_d = (count_inc < half_cur);
                    if (load_legal) begin
                        shadow_d  = div_val;
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                count_d  = '0;
                pos_hi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            pos_hi_q  <= 1'b0;
            div_cur_q <= DIV_W'(DIV_DEFAULT);
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pos_hi_q  <= pos_hi_d;
            div_cur_q <= div_cur_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // The shadow is only read when pending is set, so it needs no reset.
    always_ff @(posedge clk_in) begin
        shadow_q <= shadow_d;
    end

    // Outputs
    always_comb begin
        tick = (state_q == RUN) && at_end;
    end

    assign div_cur = div_cur_q;
    assign cfg_err = cfg_err_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
    clk_div_duty_fix u_duty_fix (
        .clk_i    (clk_in),
        .rst_ni   (reset_n),
        .pos_hi_i (pos_hi_q),
        .odd_i    (div_cur_q[0]),
        .clk_o    (clk_out)
    );
`else
    assign clk_out = pos_hi_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (default build, odd-duty stage not compiled).
module tb_clk_div_prog;

    localparam int DIV_W       = 8;
    localparam int DIV_DEFAULT = 5;

    logic             clk_in   = 1'b0;
    logic             reset_n  = 1'b0;
    logic             enable   = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             div_load = 1'b0;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] div_cur;
    logic             cfg_err;

    clk_div_prog #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .enable   (enable),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_cur  (div_cur),
        .cfg_err  (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the period, running flag, ratios.
    bit m_run;
    int m_p;
    int m_n;
    int m_sh;
    bit m_pend;
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_p    = 0;
        m_n    = DIV_DEFAULT;
        m_sh   = 0;
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        bit legal;
        legal = div_load && (int'(div_val) >= 2);
        m_err = div_load && (int'(div_val) < 2);
        if (!m_run) begin
            if (legal) m_n = int'(div_val);
            if (enable) begin
                m_run = 1'b1;
                m_p   = 0;
            end
        end else if (m_p == m_n - 1) begin
            if (legal) m_n = int'(div_val);
            else if (m_pend) m_n = m_sh;
            m_pend = 1'b0;
            m_p    = 0;
            m_run  = enable;
        end else begin
            m_p = m_p + 1;
            if (legal) begin
                m_sh   = int'(div_val);
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("clk_out", clk_out, (m_run && (m_p < (m_n + 1) / 2)));
        chk("tick",    tick,    (m_run && (m_p == m_n - 1)));
        chk("div_cur", div_cur, m_n);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic step();
        @(posedge clk_in);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic rec(input int n, output logic [63:0] c, output logic [63:0] t);
        c = '0;
        t = '0;
        for (int i = 0; i < n; i++) begin
            step();
            c[i] = clk_out;
            t[i] = tick;
        end
    endtask

    task automatic load(input int v);
        div_load = 1'b1;
        div_val  = DIV_W'(v);
    endtask

    initial begin
        logic [63:0] c;
        logic [63:0] t;
        int hi;
        int ticks;

        model_reset();
        #12;
        compare_all();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_div_cur", div_cur, 5);
        chk("rst_cfg_err", cfg_err, 0);

        // N = 5 from reset: high 3 / low 2, tick every 5th cycle
        reset_n = 1'b1;
        enable  = 1'b1;
        rec(10, c, t);
        chk("n5_first_high", c[0], 1);
        chk("n5_clk", c[9:0], 10'b0011100111);
        chk("n5_tick", t[9:0], 10'b1000010000);
        chk("n5_div_cur", div_cur, 5);

        // Load 8 mid-period: current period completes, then 4/4
        step();
        step();
        load(8);
        step();
        div_load = 1'b0;
        step();
        step();
        chk("ld8_before_wrap", div_cur, 5);
        rec(8, c, t);
        chk("n8_clk", c[7:0], 8'b00001111);
        chk("n8_tick", t[7:0], 8'b10000000);
        chk("n8_div_cur", div_cur, 8);

        // Loads of 6 then 9 in one period; an illegal load on the wrap edge
        step();
        load(6);
        step();
        load(9);
        step();
        div_load = 1'b0;
        repeat (5) step();
        chk("ld69_before_wrap", div_cur, 8);
        load(1);
        step();
        div_load = 1'b0;
        chk("ld9_applied", div_cur, 9);
        chk("cfg_err_pulse", cfg_err, 1);
        step();
        chk("cfg_err_one_cycle", cfg_err, 0);
        repeat (7) step();
        rec(9, c, t);
        chk("n9_clk", c[8:0], 9'b000011111);
        chk("n9_tick", t[8:0], 9'b100000000);

        // N = 7, drop enable at count 1: period finishes, then IDLE
        load(7);
        step();
        div_load = 1'b0;
        step();
        enable = 1'b0;
        rec(7, c, t);
        chk("n7_stop_clk", c[6:0], 7'b0000011);
        chk("n7_stop_tick", t[6:0], 7'b0010000);
        enable = 1'b1;
        step();
        chk("reenable_high", clk_out, 1);

        // N = 255 then asynchronous reset while clk_out is high
        load(255);
        step();
        div_load = 1'b0;
        repeat (6) step();
        chk("n255_applied", div_cur, 255);
        repeat (10) step();
        chk("n255_high", clk_out, 1);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        model_reset();
        #1;
        chk("async_clk_out", clk_out, 0);
        chk("async_div_cur", div_cur, 5);
        compare_all();
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_div_cur", div_cur, 5);
        load(255);
        step();
        div_load = 1'b0;
        chk("idle_load_255", div_cur, 255);
        enable = 1'b1;
        hi    = 0;
        ticks = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            hi    += int'(clk_out);
            ticks += int'(tick);
        end
        chk("n255_high_cycles", hi, 128);
        chk("n255_ticks", ticks, 1);

        // Randomised run against the model
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 15) == 15) load(int'($urandom_range(0, 255)));
                else load(int'($urandom_range(0, 12)));
            end else begin
                div_load = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
